// File: rtl/fm_pkg.sv
// Shared constants, types and tremolo shaping for the FM slot sequencer.
package fm_pkg;

    localparam int unsigned NUM_OPS          = 36;
    localparam int unsigned SLOT_W           = 6;
    localparam int unsigned TREM_STEPS       = 210;
    localparam int unsigned TREM_HALF        = 105;
    localparam int unsigned TREM_POS_W       = 8;
    localparam int unsigned AM_W             = 6;
    localparam int unsigned AM_DEEP_SHIFT    = 1;
    localparam int unsigned AM_SHALLOW_SHIFT = 3;

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_PENDING,
        CLR_CLEARING
    } clr_state_e;

    // Triangle-fold the LFO position, then scale to the selected depth.
    function automatic logic [AM_W-1:0] trem_am(input logic [TREM_POS_W-1:0] pos,
                                                input logic                  deep);
        logic [TREM_POS_W-1:0] tri_v;
        tri_v = (pos < TREM_POS_W'(TREM_HALF)) ? pos
                                               : TREM_POS_W'(TREM_STEPS - 1) - pos;
        trem_am = deep ? AM_W'(tri_v >> AM_DEEP_SHIFT) : AM_W'(tri_v >> AM_SHALLOW_SHIFT);
    endfunction

endpackage

// File: rtl/fm_tremolo_lfo.sv
// Shared tremolo LFO: steps once every TREM_DIV samples over a 210-step triangle.
module fm_tremolo_lfo
    import fm_pkg::*;
#(
    parameter int unsigned TREM_DIV = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sample_strobe,
    input  logic            dam,
    output logic [AM_W-1:0] am_val
);

    localparam int unsigned CNT_W = (TREM_DIV > 1) ? $clog2(TREM_DIV) : 1;

    logic [CNT_W-1:0]      trem_cnt_q, trem_cnt_d;
    logic [TREM_POS_W-1:0] trem_pos_q, trem_pos_d;
    logic [AM_W-1:0]       am_val_q, am_val_d;

    // dam arrives already held per slot, so am_val only moves at slot boundaries.
    always_comb begin
        trem_cnt_d = trem_cnt_q;
        trem_pos_d = trem_pos_q;
        if (sample_strobe) begin
            if (trem_cnt_q == CNT_W'(TREM_DIV - 1)) begin
                trem_cnt_d = '0;
                trem_pos_d = (trem_pos_q == TREM_POS_W'(TREM_STEPS - 1)) ? '0
                                                                         : trem_pos_q + TREM_POS_W'(1);
            end else begin
                trem_cnt_d = trem_cnt_q + CNT_W'(1);
            end
        end
        am_val_d = trem_am(trem_pos_d, dam);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trem_cnt_q <= '0;
            trem_pos_q <= '0;
            am_val_q   <= '0;
        end else begin
            trem_cnt_q <= trem_cnt_d;
            trem_pos_q <= trem_pos_d;
            am_val_q   <= am_val_d;
        end
    end

    assign am_val = am_val_q;

endmodule

// File: rtl/fm_slot_seq.sv
// Slot sequencer and timing master: walks operator slots, detects key-on edges,
// runs envelope clear sweeps and drives the shared tremolo value.
module fm_slot_seq #(
    parameter int unsigned NUM_OPS       = fm_pkg::NUM_OPS,
    parameter int unsigned CLKS_PER_SLOT = 8,
    parameter int unsigned TREM_DIV      = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      kon,
    input  logic                      dam,
    input  logic                      clear_req,
    output logic [fm_pkg::SLOT_W-1:0] op_sel,
    output logic                      next,
    output logic                      op_reset,
    output logic                      restart,
    output logic [fm_pkg::AM_W-1:0]   am_val,
    output logic                      sample_strobe
);

    import fm_pkg::*;

    localparam int unsigned      SUB_W     = (CLKS_PER_SLOT > 1) ? $clog2(CLKS_PER_SLOT) : 1;
    localparam slot_t            LAST_SLOT = SLOT_W'(NUM_OPS - 1);
    localparam logic [SUB_W-1:0] LAST_SUB  = SUB_W'(CLKS_PER_SLOT - 1);

    logic [SUB_W-1:0]   sub_q, sub_d;
    slot_t              op_sel_q, op_sel_d;
    logic               next_q, next_d;
    logic               strobe_q, strobe_d;
    logic               op_reset_q, op_reset_d;
    logic               dam_q, dam_d;
    logic               rearm_q, rearm_d;
    logic [NUM_OPS-1:0] kon_prev_q, kon_prev_d;
    clr_state_e         clr_q, clr_d;
    logic               wrap;
    logic               pend_now;

    always_comb begin
        sub_d      = next_q ? '0 : sub_q + SUB_W'(1);
        op_sel_d   = op_sel_q;
        kon_prev_d = kon_prev_q;
        dam_d      = dam_q;
        clr_d      = clr_q;
        rearm_d    = rearm_q;
        wrap       = next_q && (op_sel_q == LAST_SLOT);
        pend_now   = (clr_q == CLR_PENDING) || ((clr_q == CLR_CLEARING) && rearm_q);

        if (next_q) begin
            op_sel_d             = (op_sel_q == LAST_SLOT) ? '0 : op_sel_q + SLOT_W'(1);
            kon_prev_d[op_sel_q] = op_reset_q ? 1'b0 : kon;
            dam_d                = dam;
        end

        // A request seen during a clear sweep re-arms a follow-up sweep.
        if (wrap) begin
            clr_d   = pend_now ? CLR_CLEARING : (clear_req ? CLR_PENDING : CLR_IDLE);
            rearm_d = pend_now && clear_req;
        end else if (clear_req) begin
            if (clr_q == CLR_IDLE) begin
                clr_d = CLR_PENDING;
            end else if (clr_q == CLR_CLEARING) begin
                rearm_d = 1'b1;
            end
        end

        op_reset_d = (clr_d == CLR_CLEARING);
        next_d     = (sub_d == LAST_SUB);
        strobe_d   = next_d && (op_sel_d == LAST_SLOT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q      <= '0;
            op_sel_q   <= '0;
            next_q     <= 1'b0;
            strobe_q   <= 1'b0;
            op_reset_q <= 1'b1;
            dam_q      <= 1'b0;
            rearm_q    <= 1'b0;
            kon_prev_q <= '0;
            clr_q      <= CLR_CLEARING;
        end else begin
            sub_q      <= sub_d;
            op_sel_q   <= op_sel_d;
            next_q     <= next_d;
            strobe_q   <= strobe_d;
            op_reset_q <= op_reset_d;
            dam_q      <= dam_d;
            rearm_q    <= rearm_d;
            kon_prev_q <= kon_prev_d;
            clr_q      <= clr_d;
        end
    end

    fm_tremolo_lfo #(
        .TREM_DIV (TREM_DIV)
    ) u_lfo (
        .clk           (clk),
        .reset         (reset),
        .sample_strobe (strobe_q),
        .dam           (dam_d),
        .am_val        (am_val)
    );

    assign op_sel        = op_sel_q;
    assign next          = next_q;
    assign op_reset      = op_reset_q;
    assign sample_strobe = strobe_q;
    assign restart       = kon && !kon_prev_q[op_sel_q] && !op_reset_q;

endmodule
